// File: rtl/config_sequencer.sv
// config_sequencer: streams a bitstream, one word at a time, into a
// configuration shift chain, then pulses set_hard to latch the chain.
module config_sequencer #(
   parameter int unsigned CHAIN_LEN = 18,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              shift_enable,
   output logic              shift_data,
   output logic              set_hard,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned K_W   = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_SET,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [CNT_W-1:0]  bits_q, bits_d;
   logic [31:0]       remain_c;

   logic in_ready_q, shift_en_q, shift_data_q, set_hard_q, busy_q, done_q;

   // Next-state, word shifter and bit counters
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      k_d      = k_q;
      bits_d   = bits_q;
      remain_c = 32'(CHAIN_LEN) - 32'(bits_q);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bits_d  = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // last word may be partial: only the bits still owed to the chain
            if (in_valid) begin
               word_d  = in_data;
               k_d     = (remain_c > 32'(WORD_W)) ? K_W'(WORD_W) : K_W'(remain_c);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            word_d = word_q >> 1;
            k_d    = k_q - K_W'(1);
            bits_d = bits_q + CNT_W'(1);
            if (k_q == K_W'(1)) begin
               state_d = (bits_q == CNT_W'(CHAIN_LEN - 1)) ? S_SET : S_LOAD;
            end
         end
         S_SET:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         k_q     <= '0;
         bits_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         k_q     <= k_d;
         bits_q  <= bits_d;
      end
   end

   // Outputs registered from the next state so each tracks its state exactly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_q   <= 1'b0;
         shift_en_q   <= 1'b0;
         shift_data_q <= 1'b0;
         set_hard_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         in_ready_q   <= (state_d == S_LOAD);
         shift_en_q   <= (state_d == S_SHIFT);
         shift_data_q <= (state_d == S_SHIFT) & word_d[0];
         set_hard_q   <= (state_d == S_SET);
         busy_q       <= (state_d != S_IDLE);
         done_q       <= (state_d == S_DONE);
      end
   end

   assign in_ready     = in_ready_q;
   assign shift_enable = shift_en_q;
   assign shift_data   = shift_data_q;
   assign set_hard     = set_hard_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
